mux4_tdm_tx: RTL and testbench
==============================

Name: mux4_tdm_tx

Overview:
- 4:1 time-division multiplexing transmitter.
- Snapshots four parallel lanes once per frame, then serialises them onto one data line in lane order, one lane per slot.
- Drives the select code (s1, s0) alongside the data, so the existing 1:4 demux at the far end can steer each slot back to its lane.
- Sits at the sending end of the mux/demux link.

Parameters:
- WIDTH, 1, bit width of each lane and of output y.
- HOLD, 1, clock cycles each slot is held on the output (legal range 1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  transmit enable; low pauses the transmitter.
- lane_mask  input  4  bit k=1 means lane k is sent; sampled at each frame start.
- i0  input  WIDTH  lane 0 data.
- i1  input  WIDTH  lane 1 data.
- i2  input  WIDTH  lane 2 data.
- i3  input  WIDTH  lane 3 data.
- y  output  WIDTH  serial data for the current slot.
- s1  output  1  select MSB of the current slot's lane index.
- s0  output  1  select LSB of the current slot's lane index.
- valid  output  1  y/s1/s0 carry a live slot.
- frame_start  output  1  one-cycle pulse on the first cycle of a frame's first slot.

Behaviour:
- Clocking: all outputs registered; one clock (clk); reset is synchronous and active-high (rst).
- Reset: state IDLE; y=0, s1=0, s0=0, valid=0, frame_start=0; hold counter=0; snapshot registers=0. Reset wins over all other inputs, including mid-frame; the frame in progress is discarded.
- State IDLE, frame start: at an edge where en=1 and lane_mask!=0:
  - capture i0..i3 and lane_mask into snapshot registers;
  - sel <= lowest set bit of the mask;
  - y <= snapshot[sel], {s1,s0} <= sel, valid <= 1, frame_start <= 1, hold_cnt <= 0;
  - go to SLOT.
- Latency: one cycle from the enabling edge to the first valid output.
- IDLE with en=0 or lane_mask=0: stay IDLE; valid=0, frame_start=0; y, s1, s0 hold their last values.
- State SLOT, en=1:
  - frame_start <= 0.
  - If hold_cnt < HOLD-1: hold_cnt++; outputs unchanged.
  - Otherwise: hold_cnt <= 0 and advance sel to the next set bit of the captured mask with a higher index.
  - End of frame (no higher set bit):
    - if en=1 and the live lane_mask!=0, start the next frame back-to-back, exactly as IDLE frame start (new snapshot, frame_start=1, no gap cycle);
    - otherwise valid <= 0 and go to IDLE.
- State SLOT, en=0: pause. hold_cnt, sel and the outputs freeze; valid <= 0. When en returns to 1, valid <= 1 and the frozen slot resumes with its remaining hold count.
- Snapshot isolation: changes on i0..i3 or lane_mask during a frame do not affect that frame.
- Lane order: always ascending index; masked lanes consume no cycles.
- Frame length: popcount(mask) × HOLD cycles.
- Select encoding: {s1,s0} = lane index, matching the demux (00 routes to y0 … 11 routes to y3).

Test Plan:
- Reset and idle: assert rst for 2 cycles, en=0 -> y=0, s1=0, s0=0, valid=0, frame_start=0 on the first post-reset edge; outputs hold these values while idle.
- Full frame: WIDTH=1, HOLD=1, mask=1111, i0..i3=1,0,1,1, en held high for 4 cycles then dropped -> cycles 1-4 give {s1,s0}=00,01,10,11 and y=1,0,1,1; valid=1 throughout; frame_start=1 only in cycle 1; valid=0 in cycle 5.
- Sparse mask with hold: HOLD=2, mask=0101, i0=0, i2=1 -> {s1,s0}=00 for 2 cycles with y=0, then 10 for 2 cycles with y=1; next frame begins with no gap while en=1.
- Snapshot isolation: change i1 from 0 to 1 and mask to 0001 during slot 0 -> the current frame still sends y=0 in slot 01, and the new mask applies from the next frame.
- Pause and empty mask: drop en for 3 cycles during slot 10 -> valid=0 and outputs frozen; resume finishes slot 10, then 11. With mask=0000 and en=1, the block stays IDLE with valid=0.
- Reset mid-frame: assert rst during slot 01 -> next edge gives all outputs at reset values; after release with en=1 and mask=1111, the frame restarts at lane 00 with frame_start=1.

Source files
------------

// File: rtl/mux4_tdm_tx.sv
// mux4_tdm_tx: 4:1 time-division multiplexing transmitter.
// Once per frame it snapshots four lanes and the lane mask. It then sends every
// enabled lane in ascending order, one lane per slot, and holds each slot for
// HOLD cycles. The select code {s1,s0} goes out with the data so that the far-end
// 1:4 demux can route each slot back to its lane.
module mux4_tdm_tx #(
    parameter int WIDTH = 1,
    parameter int HOLD  = 1   // cycles per slot, 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       lane_mask,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y,
    output logic             s1,
    output logic             s0,
    output logic             valid,
    output logic             frame_start
);

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    typedef enum logic {IDLE, SLOT} state_t;

    // Live lane inputs, indexed by lane number
    logic [3:0][WIDTH-1:0] lanes_in;
    assign lanes_in = {i3, i2, i1, i0};

    state_t                state_q, state_d;
    logic [7:0]            hold_q, hold_d;
    logic [1:0]            sel_q, sel_d;
    logic [WIDTH-1:0]      y_q, y_d;
    logic                  valid_q, valid_d;
    logic                  fs_q, fs_d;
    logic [3:0][WIDTH-1:0] snap_q, snap_d;
    logic [3:0]            smask_q, smask_d;

    logic                  start;
    logic [2:0]            nxt;      // {found, lane}

    // Lowest set bit of a non-zero mask
    function automatic logic [1:0] first_lane(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (m[k]) r = 2'(k);
        return r;
    endfunction

    // Next set bit strictly above cur; MSB of the result flags whether one exists
    function automatic logic [2:0] next_lane(input logic [3:0] m, input logic [1:0] cur);
        logic [3:0] above;
        logic [2:0] r;
        above = m & (4'b1110 << cur);
        r     = 3'b000;
        for (int k = 3; k >= 0; k--)
            if (above[k]) r = {1'b1, 2'(k)};
        return r;
    endfunction

    assign nxt = next_lane(smask_q, sel_q);

    // Next-state and next-output logic: frame start, slot hold/advance, pause
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        y_d     = y_q;
        valid_d = 1'b0;
        fs_d    = 1'b0;
        snap_d  = snap_q;
        smask_d = smask_q;
        start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && lane_mask != 4'b0000) start = 1'b1;
            end
            SLOT: begin
                if (!en) begin
                    // Pause: everything frozen, only valid drops
                    valid_d = 1'b0;
                end else if (hold_q < HOLD_M1) begin
                    hold_d  = hold_q + 8'd1;
                    valid_d = 1'b1;
                end else begin
                    hold_d = 8'd0;
                    if (nxt[2]) begin
                        sel_d   = nxt[1:0];
                        y_d     = snap_q[nxt[1:0]];
                        valid_d = 1'b1;
                    end else if (lane_mask != 4'b0000) begin
                        // Back-to-back frame, no gap cycle
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            snap_d  = lanes_in;
            smask_d = lane_mask;
            sel_d   = first_lane(lane_mask);
            y_d     = lanes_in[first_lane(lane_mask)];
            valid_d = 1'b1;
            fs_d    = 1'b1;
            hold_d  = 8'd0;
            state_d = SLOT;
        end
    end

    // State and output registers; reset discards any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
            sel_q   <= 2'd0;
            y_q     <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            snap_q  <= '0;
            smask_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            snap_q  <= snap_d;
            smask_q <= smask_d;
        end
    end

    assign y           = y_q;
    assign s1          = sel_q[1];
    assign s0          = sel_q[0];
    assign valid       = valid_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_mux4_tdm_tx.sv
// Bench for mux4_tdm_tx: two instances, one with WIDTH=1/HOLD=1 (a) and one with WIDTH=4/HOLD=2 (b).
// Both share their inputs. A slot-list reference model predicts every output cycle.
module tb_mux4_tdm_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] lane_mask = 4'b0000;
    logic [3:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0;

    logic [0:0] y_a;
    logic       s1_a, s0_a, v_a, fs_a;
    logic [3:0] y_b;
    logic       s1_b, s0_b, v_b, fs_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux4_tdm_tx #(.WIDTH(1), .HOLD(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .lane_mask(lane_mask),
        .i0(i0[0:0]), .i1(i1[0:0]), .i2(i2[0:0]), .i3(i3[0:0]),
        .y(y_a), .s1(s1_a), .s0(s0_a), .valid(v_a), .frame_start(fs_a)
    );

    mux4_tdm_tx #(.WIDTH(4), .HOLD(2)) u_b (
        .clk(clk), .rst(rst), .en(en), .lane_mask(lane_mask),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .y(y_b), .s1(s1_b), .s0(s0_b), .valid(v_b), .frame_start(fs_b)
    );

    logic [15:0] obs;
    assign obs = {v_a, fs_a, s1_a, s0_a, 3'b000, y_a, v_b, fs_b, s1_b, s0_b, y_b};

    // Reference model: each frame becomes a list of (lane, data) slots.
    // Every enabled edge consumes one valid cycle of the current slot.
    int         hold_of[2] = '{1, 2};
    logic [3:0] wmask[2]   = '{4'h1, 4'hF};
    bit         busy[2]    = '{0, 0};
    int         n_sl[2], idx[2], rem[2];
    logic [1:0] fl_lane[2][4];
    logic [3:0] fl_data[2][4];
    logic [3:0] ex_y[2]   = '{4'h0, 4'h0};
    logic [1:0] ex_sel[2] = '{2'd0, 2'd0};
    logic       ex_v[2]   = '{1'b0, 1'b0};
    logic       ex_fs[2]  = '{1'b0, 1'b0};

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic [3:0] din[4];
            din = '{i0, i1, i2, i3};
            ex_fs[d] = 1'b0;
            if (rst) begin
                busy[d] = 0; ex_y[d] = 4'h0; ex_sel[d] = 2'd0; ex_v[d] = 1'b0;
            end else if (!en) begin
                ex_v[d] = 1'b0;
            end else begin
                if (busy[d]) begin
                    rem[d]--;
                    if (rem[d] == 0) begin
                        idx[d]++;
                        rem[d] = hold_of[d];
                        if (idx[d] == n_sl[d]) busy[d] = 0;
                    end
                end
                if (!busy[d] && lane_mask != 4'b0000) begin
                    n_sl[d] = 0;
                    for (int k = 0; k < 4; k++)
                        if (lane_mask[k]) begin
                            fl_lane[d][n_sl[d]] = 2'(k);
                            fl_data[d][n_sl[d]] = din[k] & wmask[d];
                            n_sl[d]++;
                        end
                    busy[d] = 1; idx[d] = 0; rem[d] = hold_of[d]; ex_fs[d] = 1'b1;
                end
                if (busy[d]) begin
                    ex_y[d]   = fl_data[d][idx[d]];
                    ex_sel[d] = fl_lane[d][idx[d]];
                    ex_v[d]   = 1'b1;
                end else begin
                    ex_v[d] = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [15:0] exp_vec();
        return {ex_v[0], ex_fs[0], ex_sel[0], ex_y[0], ex_v[1], ex_fs[1], ex_sel[1], ex_y[1]};
    endfunction

    // One clock edge: the model samples the same inputs as the DUT, then the outputs settle
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (obs !== 16'h0000) begin
                n_fail++; $display("FAIL reset c%0d: got %h, want 0000", c, obs);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL idle c%0d: got %h, want %h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_full_frame();
        logic [3:0] pat;
        pat = 4'b1101;   // y for lanes 0..3 = 1,0,1,1
        rst = 1'b1; tick(); rst = 1'b0;
        i0 = 4'h5; i1 = 4'hA; i2 = 4'h3; i3 = 4'h9;
        lane_mask = 4'b1111; en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) en = 1'b0;
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL full_frame c%0d: got %h, want %h", c, obs, exp_vec());
            end
            if (c < 4) begin
                n_tests++;
                if ({v_a, fs_a, s1_a, s0_a, y_a} !== {1'b1, (c == 0), 2'(c), pat[c]}) begin
                    n_fail++;
                    $display("FAIL full_frame_a c%0d: got v%b f%b s%b%b y%b, want v1 f%b s%0d y%b",
                             c, v_a, fs_a, s1_a, s0_a, y_a, (c == 0), c, pat[c]);
                end
            end else begin
                n_tests++;
                if (v_a !== 1'b0) begin
                    n_fail++; $display("FAIL full_frame_end: got valid %b, want 0", v_a);
                end
            end
        end
    endtask

    task automatic test_sparse_hold();
        logic [1:0] es[5];
        logic [3:0] ey[5];
        logic       ef[5];
        rst = 1'b1; tick(); rst = 1'b0;
        i0 = 4'h0; i1 = 4'hF; i2 = 4'h1; i3 = 4'hF;
        lane_mask = 4'b0101; en = 1'b1;
        es = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
        ey = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
        ef = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL sparse_hold c%0d: got %h, want %h", c, obs, exp_vec());
            end
            if (c < 5) begin
                n_tests++;
                if ({v_b, fs_b, s1_b, s0_b, y_b} !== {1'b1, ef[c], es[c], ey[c]}) begin
                    n_fail++;
                    $display("FAIL sparse_hold_b c%0d: got f%b s%b%b y%h, want f%b s%0d y%h",
                             c, fs_b, s1_b, s0_b, y_b, ef[c], es[c], ey[c]);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        rst = 1'b1; tick(); rst = 1'b0;
        i0 = 4'h1; i1 = 4'h0; i2 = 4'h2; i3 = 4'h3;
        lane_mask = 4'b1111; en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) begin i1 = 4'hF; lane_mask = 4'b0001; end
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL snapshot c%0d: got %h, want %h", c, obs, exp_vec());
            end
            if (c == 1) begin
                n_tests++;
                if ({s1_a, s0_a, y_a, s1_b, s0_b, y_b} !== {2'd1, 1'b0, 2'd0, 4'h1}) begin
                    n_fail++; $display("FAIL snapshot_slot c1: got a s%b%b y%b b s%b%b y%h, want a s01 y0 b s00 y1",
                                       s1_a, s0_a, y_a, s1_b, s0_b, y_b);
                end
            end
            if (c == 4 || c == 5) begin
                n_tests++;
                if ({v_a, fs_a, s1_a, s0_a} !== 4'b1100) begin
                    n_fail++; $display("FAIL snapshot_newmask c%0d: got v%b f%b s%b%b, want v1 f1 s00",
                                       c, v_a, fs_a, s1_a, s0_a);
                end
            end
        end
    endtask

    task automatic test_pause();
        rst = 1'b1; tick(); rst = 1'b0;
        i0 = 4'h4; i1 = 4'h5; i2 = 4'h6; i3 = 4'h7;
        lane_mask = 4'b1111; en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            en = !(c >= 5 && c <= 7);
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL pause c%0d: got %h, want %h", c, obs, exp_vec());
            end
            if (c >= 5 && c <= 7) begin
                n_tests++;
                if ({v_b, s1_b, s0_b, y_b} !== {1'b0, 2'd2, 4'h6}) begin
                    n_fail++; $display("FAIL pause_frozen c%0d: got v%b s%b%b y%h, want v0 s10 y6",
                                       c, v_b, s1_b, s0_b, y_b);
                end
            end
            if (c == 8 || c == 9) begin
                n_tests++;
                if ({v_b, s1_b, s0_b} !== {1'b1, (c == 8) ? 2'd2 : 2'd3}) begin
                    n_fail++; $display("FAIL pause_resume c%0d: got v%b s%b%b", c, v_b, s1_b, s0_b);
                end
            end
        end
        rst = 1'b1; tick(); rst = 1'b0;
        lane_mask = 4'b0000; en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if ({v_a, fs_a, v_b, fs_b} !== 4'b0000 || obs !== exp_vec()) begin
                n_fail++; $display("FAIL empty_mask c%0d: got %h, want %h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; tick(); rst = 1'b0;
        i0 = 4'h8; i1 = 4'h9; i2 = 4'hA; i3 = 4'hB;
        lane_mask = 4'b1111; en = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (obs !== 16'h0000) begin
            n_fail++; $display("FAIL reset_mid: got %h, want 0000", obs);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({v_b, fs_b, s1_b, s0_b, y_b} !== {1'b1, 1'b1, 2'd0, 4'h8} || obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_restart: got %h, want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            en        = ($urandom_range(0, 99) < 85);
            lane_mask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            i0 = 4'($urandom); i1 = 4'($urandom); i2 = 4'($urandom); i3 = 4'($urandom);
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random c%0d: got %h, want %h", c, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_sparse_hold();
        test_snapshot();
        test_pause();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
